maze_dot_eater: RTL and testbench
=================================

# maze_dot_eater

Maze-state writer for the Pacman playfield. Owns the write port of the 30x40 maze tile RAM: on power-up or level restart it loads the RAM from the maze ROM and counts the edible tiles. Once per frame it reads the tile under Pacman's centre, clears it if it is a dot or power pellet, and updates score, dots-remaining and level-clear status. It sits beside the Pacman movement block and reads the same `PacmanX`/`PacmanY`. The movement block and the tile renderer read the RAM this block writes.

## Interface
Parameters:
- `ROWS`, 30: maze rows.
- `COLS`, 40: maze columns.
- `TILE_SHIFT`, 4: log2 of the tile size in pixels (16).
- `DOT_POINTS`, 10: score added for a dot tile.
- `POWER_POINTS`, 50: score added for a power-pellet tile.

Ports (clock and reset first):
- `Clk`  in  1: system clock.
- `Reset_n`  in  1: reset, asynchronous, active-low.
- `frame_tick`  in  1: one-`Clk` pulse per video frame.
- `restart`  in  1: one-cycle pulse; reload the maze for a new level.
- `game_over`  in  1: level requests are ignored while high.
- `PacmanX`, `PacmanY`  in  10 each: Pacman centre, in pixels.
- `mem_addr`  out  11: RAM address (row*COLS+col); the same address goes to the ROM.
- `mem_we`  out  1: RAM write enable.
- `mem_wdata`  out  8: RAM write data.
- `mem_rdata`  in  8: RAM read data, valid one cycle after `mem_addr`.
- `rom_rdata`  in  8: maze ROM data, valid one cycle after `mem_addr`.
- `score`  out  16: accumulated score.
- `dots_left`  out  9: edible tiles remaining.
- `level_clear`  out  1: asserted when `dots_left` reaches 0.
- `power_pulse`  out  1: one-cycle pulse when a power pellet is eaten.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: INIT, IDLE, READ, EVAL.
- Reset values:
  - state INIT; `mem_addr` 0; `mem_we` 0; `mem_wdata` 0x00.
  - `score` 0; `dots_left` 0; `level_clear` 0; `power_pulse` 0.
  - `busy` 1.
- INIT (copy the ROM into the RAM):
  - Address counter k steps from 0 to ROWS*COLS-1.
  - Cycle k drives `mem_addr`=k with `mem_we`=0 toward the ROM.
  - Cycle k+1 writes `rom_rdata` to RAM address k (`mem_we`=1) and increments `dots_left` if that tile is TILE_DOT (0x02) or TILE_POWER (0x03).
  - Reads and writes are pipelined, so INIT lasts ROWS*COLS+1 cycles, then the FSM goes to IDLE.
  - `level_clear` clears on entry to INIT.
- IDLE: on `frame_tick` with `game_over`=0, `restart`=0 and `level_clear`=0, compute the tile:
  - row = `PacmanY`>>TILE_SHIFT; col = `PacmanX`>>TILE_SHIFT.
  - If row>=ROWS or col>=COLS, stay in IDLE with no RAM access.
  - Otherwise go to READ.
- Address arithmetic: row*40 = (row<<5)+(row<<3); add col; the result is 11 bits wide with no overflow.
- READ: drive `mem_addr`, `mem_we`=0, then go to EVAL.
- EVAL: `mem_rdata` is valid in this state.
  - TILE_DOT: `mem_we`=1, `mem_wdata`=MOVE_TILE (0x00) at the same address; `score` += DOT_POINTS; `dots_left` -= 1.
  - TILE_POWER: same write and decrement; `score` += POWER_POINTS; `power_pulse` goes high the next cycle.
  - Any other tile: no write and no counter change.
  - Next state is always IDLE.
- `score` saturates at 0xFFFF. `dots_left` never decrements below 0.
- `level_clear` is registered: it goes high in the cycle after `dots_left` becomes 0 outside INIT, and holds until `restart` or reset.
- `restart` from any state jumps to INIT next cycle and aborts any read or write in flight. `score` is retained; `dots_left` restarts at 0.
- If `restart` and `frame_tick` arrive together, `restart` wins.
- `frame_tick` while `busy` is dropped, not queued.

## Timing
- `frame_tick` at cycle T (IDLE):
  - T+1: READ, `mem_addr` valid.
  - T+2: EVAL, `mem_rdata` sampled, `mem_we` asserted combinationally from FSM and `mem_rdata`.
  - T+3: `score`, `dots_left` and `power_pulse` updated; state IDLE.
- `busy` is high at T+1 and T+2.
- After reset deassertion, `busy` falls ROWS*COLS+1 = 1201 cycles later.
- All outputs are registered except `mem_we`, `mem_wdata` and `mem_addr` during EVAL and the INIT write phase.
- Reset assertion mid-operation forces the reset values asynchronously. Any write cut off that way is a don't-care; INIT rewrites the whole RAM.

## Structure
- Shared package `maze_pkg` holds:
  - tile codes: MOVE_TILE, TILE_WALL, TILE_DOT, TILE_POWER=0x03, wall-shape codes, GHOST_GATE;
  - `MAZE_ROWS`, `MAZE_COLS`, `TILE_SHIFT`;
  - the FSM state enum type.
- One combinational sub-module, `tile_addr_calc`: pixel X/Y to {in_range, 11-bit address}. The movement block can reuse it.

## Test plan
- Reset, then a ROM holding 3 dots and 1 power pellet -> `busy` falls after 1201 cycles; RAM equals ROM; `dots_left`=4; `score`=0.
- Pacman at (40,40), tile (2,2)=TILE_DOT, one `frame_tick` -> write of 0x00 at address 82 in EVAL; `score`=10 and `dots_left`=3 at T+3.
- Same tile ticked again -> no write; `score` stays 10.
- Power pellet eaten -> `score` +50; `power_pulse` high for exactly one cycle; eating the last edible tile -> `level_clear`=1 the cycle after `dots_left`=0.
- `PacmanX`=650 -> no access, state stays IDLE; `game_over`=1 with `frame_tick` -> no access.
- `restart` in the same cycle as `frame_tick` while in READ -> INIT next cycle, `level_clear`=0, `score` retained; `Reset_n` low mid-INIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze definitions: tile codes, playfield geometry and the dot-eater FSM states.
package maze_pkg;

    localparam int unsigned MAZE_ROWS  = 30;
    localparam int unsigned MAZE_COLS  = 40;
    localparam int unsigned TILE_SHIFT = 4;

    // Tile codes stored in the maze RAM/ROM
    localparam logic [7:0] MOVE_TILE      = 8'h00;
    localparam logic [7:0] TILE_WALL      = 8'h01;
    localparam logic [7:0] TILE_DOT       = 8'h02;
    localparam logic [7:0] TILE_POWER     = 8'h03;
    localparam logic [7:0] WALL_HORIZ     = 8'h04;
    localparam logic [7:0] WALL_VERT      = 8'h05;
    localparam logic [7:0] WALL_CORNER_TL = 8'h06;
    localparam logic [7:0] WALL_CORNER_TR = 8'h07;
    localparam logic [7:0] WALL_CORNER_BL = 8'h08;
    localparam logic [7:0] WALL_CORNER_BR = 8'h09;
    localparam logic [7:0] GHOST_GATE     = 8'h0A;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StRead,
        StEval
    } maze_state_e;

    function automatic logic is_edible(input logic [7:0] tile);
        return (tile == TILE_DOT) || (tile == TILE_POWER);
    endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Pixel position to maze tile address; shared with the movement block.
module tile_addr_calc #(
    parameter int unsigned ROWS       = 30,
    parameter int unsigned COLS       = 40,
    parameter int unsigned TILE_SHIFT = 4
) (
    input  logic [9:0]  pix_x_i,
    input  logic [9:0]  pix_y_i,
    output logic        in_range_o,
    output logic [10:0] addr_o
);

    logic [9:0] row;
    logic [9:0] col;

    // Tile coordinates, bounds check and row*40+col via shift-and-add
    always_comb begin
        row        = pix_y_i >> TILE_SHIFT;
        col        = pix_x_i >> TILE_SHIFT;
        in_range_o = (32'(row) < ROWS) && (32'(col) < COLS);
        addr_o     = ({1'b0, row} << 5) + ({1'b0, row} << 3) + {1'b0, col};
    end

endmodule

// File: rtl/maze_dot_eater.sv
// Maze-state writer: copies the ROM into the tile RAM, then eats the tile under Pacman each frame.
// The RAM and ROM sample mem_addr and return data a cycle later; a write lands on the address
// sampled in the previous cycle, which is the fetch address in INIT and the held tile in EVAL.
module maze_dot_eater #(
    parameter int unsigned ROWS         = 30,
    parameter int unsigned COLS         = 40,
    parameter int unsigned TILE_SHIFT   = 4,
    parameter int unsigned DOT_POINTS   = 10,
    parameter int unsigned POWER_POINTS = 50
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        restart,
    input  logic        game_over,
    input  logic [9:0]  PacmanX,
    input  logic [9:0]  PacmanY,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic [7:0]  rom_rdata,
    output logic [15:0] score,
    output logic [8:0]  dots_left,
    output logic        level_clear,
    output logic        power_pulse,
    output logic        busy
);

    import maze_pkg::*;

    localparam logic [10:0] LastAddr = 11'(ROWS * COLS - 1);

    maze_state_e state_q, state_d;
    logic [10:0] addr_q, addr_d;
    logic        init_wr_q, init_wr_d;     // ROM data for the previous address is valid
    logic        init_last_q, init_last_d; // final INIT cycle: write only, no new fetch
    logic [15:0] score_q, score_d;
    logic [8:0]  dots_q, dots_d;
    logic        level_clear_q, level_clear_d;
    logic        power_pulse_q, power_pulse_d;
    logic [16:0] score_sum;
    logic        tile_in_range;
    logic [10:0] tile_addr;

    tile_addr_calc #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .TILE_SHIFT (TILE_SHIFT)
    ) u_tile_addr (
        .pix_x_i    (PacmanX),
        .pix_y_i    (PacmanY),
        .in_range_o (tile_in_range),
        .addr_o     (tile_addr)
    );

    // Next-state, counter updates and the combinational RAM write strobe
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        init_wr_d     = init_wr_q;
        init_last_d   = init_last_q;
        score_d       = score_q;
        dots_d        = dots_q;
        power_pulse_d = 1'b0;
        level_clear_d = level_clear_q | ((state_q != StInit) && (dots_q == '0));
        mem_we        = 1'b0;
        mem_wdata     = MOVE_TILE;
        score_sum     = '0;

        case (state_q)
            StInit: begin
                if (init_wr_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = rom_rdata;
                    if (is_edible(rom_rdata) && (dots_q != '1)) begin
                        dots_d = dots_q + 9'd1;
                    end
                end
                init_wr_d = 1'b1;
                if (init_last_q) begin
                    state_d = StIdle;
                end else if (addr_q == LastAddr) begin
                    init_last_d = 1'b1;
                end else begin
                    addr_d = addr_q + 11'd1;
                end
            end
            StIdle: begin
                if (frame_tick && !game_over && !restart && !level_clear_q && tile_in_range) begin
                    state_d = StRead;
                    addr_d  = tile_addr;
                end
            end
            StRead: begin
                state_d = StEval;
            end
            StEval: begin
                if (is_edible(mem_rdata)) begin
                    mem_we    = 1'b1;
                    mem_wdata = MOVE_TILE;
                    score_sum = {1'b0, score_q} + ((mem_rdata == TILE_POWER) ?
                                17'(POWER_POINTS) : 17'(DOT_POINTS));
                    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (dots_q != '0) begin
                        dots_d = dots_q - 9'd1;
                    end
                    power_pulse_d = (mem_rdata == TILE_POWER);
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Restart overrides everything and cancels any access in flight; score survives
        if (restart) begin
            state_d       = StInit;
            addr_d        = '0;
            init_wr_d     = 1'b0;
            init_last_d   = 1'b0;
            score_d       = score_q;
            dots_d        = '0;
            level_clear_d = 1'b0;
            power_pulse_d = 1'b0;
            mem_we        = 1'b0;
            mem_wdata     = MOVE_TILE;
        end
    end

    // State and counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StInit;
            addr_q        <= '0;
            init_wr_q     <= 1'b0;
            init_last_q   <= 1'b0;
            score_q       <= '0;
            dots_q        <= '0;
            level_clear_q <= 1'b0;
            power_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            init_wr_q     <= init_wr_d;
            init_last_q   <= init_last_d;
            score_q       <= score_d;
            dots_q        <= dots_d;
            level_clear_q <= level_clear_d;
            power_pulse_q <= power_pulse_d;
        end
    end

    assign mem_addr    = addr_q;
    assign score       = score_q;
    assign dots_left   = dots_q;
    assign level_clear = level_clear_q;
    assign power_pulse = power_pulse_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_maze_dot_eater.sv
// Directed bench for maze_dot_eater with behavioural maze RAM and ROM.
module tb_maze_dot_eater;

    import maze_pkg::*;

    localparam int NumTiles = 1200;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_tick;
    logic        restart;
    logic        game_over;
    logic [9:0]  PacmanX;
    logic [9:0]  PacmanY;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  rom_rdata;
    logic [15:0] score;
    logic [8:0]  dots_left;
    logic        level_clear;
    logic        power_pulse;
    logic        busy;

    logic [7:0]  rom [0:NumTiles-1];
    logic [7:0]  ram [0:NumTiles-1];
    logic [10:0] addr_r = '0;

    int checks = 0;
    int errors = 0;
    int cnt;
    int mism;

    always #5 Clk = ~Clk;

    maze_dot_eater dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .restart     (restart),
        .game_over   (game_over),
        .PacmanX     (PacmanX),
        .PacmanY     (PacmanY),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .rom_rdata   (rom_rdata),
        .score       (score),
        .dots_left   (dots_left),
        .level_clear (level_clear),
        .power_pulse (power_pulse),
        .busy        (busy)
    );

    // Synchronous-read memories; writes land on the previously sampled address
    always @(posedge Clk) begin
        addr_r <= mem_addr;
        if (mem_we === 1'b1) ram[addr_r] <= mem_wdata;
    end
    assign mem_rdata = ram[addr_r];
    assign rom_rdata = rom[addr_r];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse frame_tick for one cycle; returns at the negedge of T+1
    task automatic do_tick(input logic [9:0] x, input logic [9:0] y);
        PacmanX    = x;
        PacmanY    = y;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge Clk);
            n++;
        end
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        restart    = 1'b0;
        game_over  = 1'b0;
        PacmanX    = '0;
        PacmanY    = '0;
        for (int i = 0; i < NumTiles; i++) begin
            rom[i] = (i % 7 == 0) ? TILE_WALL : MOVE_TILE;
            ram[i] = 8'hAA;
        end
        rom[82]  = TILE_DOT;   // tile (2,2)
        rom[41]  = TILE_DOT;   // tile (1,1)
        rom[420] = TILE_DOT;   // tile (10,20)
        rom[125] = TILE_POWER; // tile (3,5)

        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(busy), 1);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_score", 32'(score), 0);
        check("rst_dots", 32'(dots_left), 0);
        check("rst_lc", 32'(level_clear), 0);
        check("rst_pp", 32'(power_pulse), 0);

        Reset_n = 1'b1;
        wait_idle(2000, cnt);
        check("init_len", 32'(cnt), 1201);
        mism = 0;
        for (int i = 0; i < NumTiles; i++) if (ram[i] !== rom[i]) mism++;
        check("ram_copy", 32'(mism), 0);
        check("init_dots", 32'(dots_left), 4);
        check("init_score", 32'(score), 0);

        // Dot at tile (2,2)
        do_tick(10'd40, 10'd40);
        check("read_busy", 32'(busy), 1);
        check("read_addr", 32'(mem_addr), 82);
        check("read_we", 32'(mem_we), 0);
        @(negedge Clk);
        check("eval_we", 32'(mem_we), 1);
        check("eval_wdata", 32'(mem_wdata), 0);
        check("eval_addr", 32'(mem_addr), 82);
        @(negedge Clk);
        check("dot_score", 32'(score), 10);
        check("dot_dots", 32'(dots_left), 3);
        check("dot_idle", 32'(busy), 0);
        check("dot_cleared", 32'(ram[82]), 32'(MOVE_TILE));

        // Same tile again: already eaten
        do_tick(10'd40, 10'd40);
        @(negedge Clk);
        check("retick_we", 32'(mem_we), 0);
        @(negedge Clk);
        check("retick_score", 32'(score), 10);
        check("retick_dots", 32'(dots_left), 3);

        // Power pellet at tile (3,5)
        do_tick(10'd88, 10'd56);
        @(negedge Clk);
        check("pow_we", 32'(mem_we), 1);
        @(negedge Clk);
        check("pow_score", 32'(score), 60);
        check("pow_dots", 32'(dots_left), 2);
        check("pow_pulse", 32'(power_pulse), 1);
        @(negedge Clk);
        check("pow_pulse_end", 32'(power_pulse), 0);

        // Off-maze column and game-over ticks are ignored
        do_tick(10'd650, 10'd40);
        check("oor_busy", 32'(busy), 0);
        check("oor_we", 32'(mem_we), 0);
        game_over = 1'b1;
        do_tick(10'd24, 10'd24);
        check("go_busy", 32'(busy), 0);
        game_over = 1'b0;
        @(negedge Clk);
        check("go_dots", 32'(dots_left), 2);

        // Remaining dots
        do_tick(10'd24, 10'd24);
        repeat (2) @(negedge Clk);
        check("d41_score", 32'(score), 70);
        check("d41_dots", 32'(dots_left), 1);
        do_tick(10'd328, 10'd168);
        repeat (2) @(negedge Clk);
        check("last_score", 32'(score), 80);
        check("last_dots", 32'(dots_left), 0);
        check("lc_not_yet", 32'(level_clear), 0);
        @(negedge Clk);
        check("lc_set", 32'(level_clear), 1);
        do_tick(10'd40, 10'd40);
        check("lc_blocks_tick", 32'(busy), 0);

        // Plain restart reloads the maze and keeps the score
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        check("rs_lc", 32'(level_clear), 0);
        check("rs_busy", 32'(busy), 1);
        check("rs_score", 32'(score), 80);
        wait_idle(2000, cnt);
        check("rs_init_len", 32'(cnt), 1201);
        check("rs_dots", 32'(dots_left), 4);

        // Restart together with frame_tick while in READ
        do_tick(10'd40, 10'd40);
        check("rr_addr", 32'(mem_addr), 82);
        restart    = 1'b1;
        frame_tick = 1'b1;
        @(negedge Clk);
        restart    = 1'b0;
        frame_tick = 1'b0;
        check("rr_busy", 32'(busy), 1);
        check("rr_lc", 32'(level_clear), 0);
        check("rr_score", 32'(score), 80);
        check("rr_addr0", 32'(mem_addr), 0);
        check("rr_we", 32'(mem_we), 0);
        check("rr_dots", 32'(dots_left), 0);
        check("rr_no_write", 32'(ram[82]), 32'(TILE_DOT));

        // Asynchronous reset in the middle of INIT
        repeat (100) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 1);
        check("ar_addr", 32'(mem_addr), 0);
        check("ar_we", 32'(mem_we), 0);
        check("ar_wdata", 32'(mem_wdata), 0);
        check("ar_score", 32'(score), 0);
        check("ar_dots", 32'(dots_left), 0);
        check("ar_lc", 32'(level_clear), 0);
        check("ar_pp", 32'(power_pulse), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
